// File: rtl/mio_bus_ctrl.sv
// mio_bus_ctrl
//   Memory/IO bus controller between the multi-cycle CPU and its RAM plus
//   N_CH IO channels. Each CPU access is latched in IDLE and decoded either to
//   RAM (fixed RAM_LAT read latency) or to one IO channel (waits for that
//   channel's ack, bounded by TIMEOUT). Every access ends with a one-cycle
//   mio_ready pulse. An IO timeout also pulses bus_err and returns all-ones.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   cpu_req/we/addr/wdata CPU request side; cpu_req is held until mio_ready
//   cpu_rdata             read data, valid in the mio_ready cycle, then held
//   mio_ready, bus_err    completion pulse, IO-timeout pulse (with mio_ready)
//   ram_addr/din/we       RAM word address, write data, write enable
//   ram_dout              RAM read data; it must be valid RAM_LAT cycles after
//                         ram_addr changes (ram_addr is itself a register)
//   io_addr/wdata/we      IO register offset, write data, write qualifier
//   io_sel                one-hot channel strobe, held until ack or timeout
//   io_rdata, io_ack      per-channel read data (ch k at [k*DW +: DW]) and ack
module mio_bus_ctrl #(
    parameter int         DW      = 32,
    parameter int         AW      = 10,
    parameter int         RAM_LAT = 1,
    parameter int         N_CH    = 4,
    parameter logic [3:0] IO_NIB  = 4'hE,
    parameter int         TIMEOUT = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cpu_req,
    input  logic                 cpu_we,
    input  logic [31:0]          cpu_addr,
    input  logic [DW-1:0]        cpu_wdata,
    output logic [DW-1:0]        cpu_rdata,
    output logic                 mio_ready,
    output logic                 bus_err,
    output logic [AW-1:0]        ram_addr,
    output logic [DW-1:0]        ram_din,
    output logic                 ram_we,
    input  logic [DW-1:0]        ram_dout,
    output logic [7:0]           io_addr,
    output logic [DW-1:0]        io_wdata,
    output logic                 io_we,
    output logic [N_CH-1:0]      io_sel,
    input  logic [N_CH*DW-1:0]   io_rdata,
    input  logic [N_CH-1:0]      io_ack
);

    localparam int CHW = $clog2(N_CH);
    // One counter serves both the RAM latency countdown and the IO wait count.
    localparam int CW  = $clog2((TIMEOUT > RAM_LAT ? TIMEOUT : RAM_LAT) + 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_RAM_WR  = 3'd1;
    localparam logic [2:0] S_RAM_RD  = 3'd2;
    localparam logic [2:0] S_IO_WAIT = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;

    typedef struct packed {
        logic           we;
        logic           is_io;
        logic [CHW-1:0] ch;
        logic [DW-1:0]  wdata;
    } req_t;

    logic [2:0]    state;
    logic [CW-1:0] cnt;
    req_t          req_q;
    logic          err_q;
    logic [DW-1:0] ch_rdata;
    logic          hit_io;

    // Address bits outside the decoded fields are don't-care.
    logic unused_addr_bits;
    assign unused_addr_bits = ^cpu_addr;

    assign hit_io = (cpu_addr[31:28] == IO_NIB);

    // Read-data slice of the latched channel.
    always_comb begin
        ch_rdata = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (req_q.ch == CHW'(k)) ch_rdata = io_rdata[k*DW +: DW];
        end
    end

    // Strobes decode from state, so a reset clears them on the next cycle.
    generate
        for (genvar k = 0; k < N_CH; k++) begin : g_sel
            assign io_sel[k] = (state == S_IO_WAIT) && (req_q.ch == CHW'(k));
        end
    endgenerate

    assign mio_ready = (state == S_DONE);
    assign bus_err   = (state == S_DONE) && err_q;
    assign ram_we    = (state == S_RAM_WR);
    assign io_we     = (state == S_IO_WAIT) && req_q.we;
    assign ram_din   = req_q.wdata;
    assign io_wdata  = req_q.wdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            req_q     <= '0;
            err_q     <= 1'b0;
            ram_addr  <= '0;
            io_addr   <= '0;
            cpu_rdata <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cpu_req) begin
                        req_q.we    <= cpu_we;
                        req_q.is_io <= hit_io;
                        req_q.ch    <= cpu_addr[10 +: CHW];
                        req_q.wdata <= cpu_wdata;
                        ram_addr    <= cpu_addr[AW+1:2];
                        io_addr     <= cpu_addr[9:2];
                        err_q       <= 1'b0;
                        if (hit_io) begin
                            state <= S_IO_WAIT;
                            cnt   <= CW'(1);
                        end else if (cpu_we) begin
                            state <= S_RAM_WR;
                        end else begin
                            state <= S_RAM_RD;
                            cnt   <= CW'(RAM_LAT - 1);
                        end
                    end
                end
                S_RAM_WR: state <= S_DONE;
                S_RAM_RD: begin
                    if (cnt == '0) begin
                        cpu_rdata <= ram_dout;
                        state     <= S_DONE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_IO_WAIT: begin
                    // Ack is tested first so it wins over a same-cycle timeout.
                    if (io_ack[req_q.ch]) begin
                        if (!req_q.we) cpu_rdata <= ch_rdata;
                        state <= S_DONE;
                    end else if (cnt == CW'(TIMEOUT)) begin
                        cpu_rdata <= '1;
                        err_q     <= 1'b1;
                        state     <= S_DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mio_bus_ctrl.sv
// Bench for mio_bus_ctrl: two instances (RAM_LAT=1 and RAM_LAT=3) share the
// CPU address/data and IO inputs but have separate cpu_req lines. Each access
// pushes its expected completion into a per-instance queue; a monitor per
// instance pops and compares whenever mio_ready is seen.
module tb_mio_bus_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        req_a, req_b, cpu_we;
    logic [31:0] cpu_addr, cpu_wdata;
    logic [127:0] io_rdata = {32'h3333_3333, 32'h0000_0055, 32'h0000_0011, 32'hDEAD_0000};
    logic [3:0]  io_ack = 4'b0;

    logic [31:0] rd_a, rdin_a, dout_a, iwd_a, rd_b, rdin_b, dout_b, iwd_b;
    logic        rdy_a, err_a, rwe_a, iwe_a, rdy_b, err_b, rwe_b, iwe_b;
    logic [9:0]  ra_a, ra_b;
    logic [7:0]  ia_a, ia_b;
    logic [3:0]  sel_a, sel_b;

    mio_bus_ctrl #(.RAM_LAT(1)) u_a (
        .clk(clk), .rst(rst), .cpu_req(req_a), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(rd_a), .mio_ready(rdy_a), .bus_err(err_a),
        .ram_addr(ra_a), .ram_din(rdin_a), .ram_we(rwe_a), .ram_dout(dout_a),
        .io_addr(ia_a), .io_wdata(iwd_a), .io_we(iwe_a), .io_sel(sel_a),
        .io_rdata(io_rdata), .io_ack(io_ack));

    mio_bus_ctrl #(.RAM_LAT(3)) u_b (
        .clk(clk), .rst(rst), .cpu_req(req_b), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(rd_b), .mio_ready(rdy_b), .bus_err(err_b),
        .ram_addr(ra_b), .ram_din(rdin_b), .ram_we(rwe_b), .ram_dout(dout_b),
        .io_addr(ia_b), .io_wdata(iwd_b), .io_we(iwe_b), .io_sel(sel_b),
        .io_rdata(io_rdata), .io_ack(io_ack));

    // RAM models. Latency counts from the controller's registered address:
    // latency 1 is a direct read, latency 3 adds two pipeline registers.
    logic [31:0] mem_a [0:1023];
    logic [31:0] mem_b [0:1023];
    logic [31:0] pb1, pb2;
    assign dout_a = mem_a[ra_a];
    assign dout_b = pb2;
    always @(posedge clk) begin
        if (rwe_a) mem_a[ra_a] <= rdin_a;
        if (rwe_b) mem_b[ra_b] <= rdin_b;
        pb1 <= mem_b[ra_b];
        pb2 <= pb1;
    end

    // IO responder for instance B: ack_bits asserted in the ack_at-th cycle of
    // io_sel (0 = never); stray_bits asserted on every selected cycle.
    int         ack_at = 0;
    int         sel_run = 0;
    logic [3:0] ack_bits = 4'b0;
    logic [3:0] stray_bits = 4'b0;
    always @(negedge clk) begin
        if (sel_b != 4'b0) begin
            sel_run++;
            io_ack = stray_bits | ((sel_run == ack_at) ? ack_bits : 4'b0);
        end else begin
            sel_run = 0;
            io_ack  = 4'b0;
        end
    end

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          we_cnt;
        logic [9:0]  waddr;
        int          sel_cnt;
        logic [3:0]  sel;
        logic [7:0]  ioaddr;
        logic        iowe;
        int          issue;
    } rec_t;

    rec_t q_a[$];
    rec_t q_b[$];
    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic rec_t mk(input logic [31:0] rd, input logic err, input int lat,
                                input int wc, input logic [9:0] wa, input int sc,
                                input logic [3:0] sel, input logic [7:0] ia, input logic iw);
        rec_t r;
        r.rdata = rd; r.err = err; r.lat = lat; r.we_cnt = wc; r.waddr = wa;
        r.sel_cnt = sc; r.sel = sel; r.ioaddr = ia; r.iowe = iw; r.issue = 0;
        return r;
    endfunction

    task automatic score(input string t, input rec_t e, input rec_t o);
        check({t, "_rdata"}, o.rdata, e.rdata);
        check({t, "_bus_err"}, 32'(o.err), 32'(e.err));
        check({t, "_latency"}, o.lat, e.lat);
        check({t, "_ram_we_cycles"}, o.we_cnt, e.we_cnt);
        if (e.we_cnt > 0) check({t, "_ram_addr"}, 32'(o.waddr), 32'(e.waddr));
        check({t, "_io_sel_cycles"}, o.sel_cnt, e.sel_cnt);
        if (e.sel_cnt > 0) begin
            check({t, "_io_sel"}, 32'(o.sel), 32'(e.sel));
            check({t, "_io_addr"}, 32'(o.ioaddr), 32'(e.ioaddr));
            check({t, "_io_we"}, 32'(o.iowe), 32'(e.iowe));
        end
    endtask

    // Monitors: accumulate strobe activity, score on each mio_ready.
    int wc_a, sc_a, wc_b, sc_b;
    logic [9:0] wa_a, wa_b;
    logic [3:0] so_a, so_b;
    logic [7:0] oa_a, oa_b;
    logic       ow_a, ow_b;

    always @(negedge clk) begin
        rec_t e, o;
        if (rst) begin
            wc_a = 0; sc_a = 0; so_a = 4'b0;
        end else begin
            if (rwe_a) begin wc_a++; wa_a = ra_a; end
            if (sel_a != 4'b0) begin sc_a++; so_a |= sel_a; oa_a = ia_a; ow_a = iwe_a; end
            if (rdy_a) begin
                check("a_ready_expected", 32'(q_a.size() != 0), 32'd1);
                if (q_a.size() != 0) begin
                    e = q_a.pop_front();
                    o = mk(rd_a, err_a, cyc - e.issue, wc_a, wa_a, sc_a, so_a, oa_a, ow_a);
                    score("a", e, o);
                end
                wc_a = 0; sc_a = 0; so_a = 4'b0;
            end
        end
    end

    always @(negedge clk) begin
        rec_t e, o;
        if (rst) begin
            wc_b = 0; sc_b = 0; so_b = 4'b0;
        end else begin
            if (rwe_b) begin wc_b++; wa_b = ra_b; end
            if (sel_b != 4'b0) begin sc_b++; so_b |= sel_b; oa_b = ia_b; ow_b = iwe_b; end
            if (rdy_b) begin
                check("b_ready_expected", 32'(q_b.size() != 0), 32'd1);
                if (q_b.size() != 0) begin
                    e = q_b.pop_front();
                    o = mk(rd_b, err_b, cyc - e.issue, wc_b, wa_b, sc_b, so_b, oa_b, ow_b);
                    score("b", e, o);
                end
                wc_b = 0; sc_b = 0; so_b = 4'b0;
            end
        end
    end

    task automatic zchk(input string t, input logic [31:0] rd, input logic [31:0] rdin,
                        input logic [31:0] iwd, input logic [9:0] ra, input logic [7:0] ia,
                        input logic [3:0] sel, input logic rdy, input logic err,
                        input logic rwe, input logic iwe);
        check({t, "_rdata"}, rd, 32'h0);
        check({t, "_ram_din"}, rdin, 32'h0);
        check({t, "_io_wdata"}, iwd, 32'h0);
        check({t, "_addrs"}, {14'b0, ra, ia}, 32'h0);
        check({t, "_ctl"}, {24'b0, sel, rdy, err, rwe, iwe}, 32'h0);
    endtask

    // One access on instance A (inst_b=0) or B. CPU address/data are scrambled
    // after the sample edge; the controller must work from its latched copy.
    task automatic access(input bit inst_b, input logic we, input logic [31:0] addr,
                          input logic [31:0] wd, input rec_t e, input bit early_drop);
        bit done = 1'b0;
        @(negedge clk);
        cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
        e.issue = cyc;
        if (inst_b) begin req_b = 1'b1; q_b.push_back(e); end
        else        begin req_a = 1'b1; q_a.push_back(e); end
        @(negedge clk);
        cpu_addr = ~addr; cpu_wdata = ~wd;
        if (early_drop) begin req_a = 1'b0; req_b = 1'b0; end
        for (int i = 0; i < 60 && !done; i++) begin
            if (inst_b ? rdy_b : rdy_a) done = 1'b1;
            else @(negedge clk);
        end
        check("access_completes", 32'(done), 32'd1);
        req_a = 1'b0; req_b = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        req_a = 1'b0; req_b = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        repeat (3) @(negedge clk);
        zchk("reset_a", rd_a, rdin_a, iwd_a, ra_a, ia_a, sel_a, rdy_a, err_a, rwe_a, iwe_a);
        zchk("reset_b", rd_b, rdin_b, iwd_b, ra_b, ia_b, sel_b, rdy_b, err_b, rwe_b, iwe_b);
        rst = 1'b0;

        // RAM write to word 4, both latencies
        access(0, 1, 32'h0000_0010, 32'hA5A5_1234, mk(32'h0, 0, 2, 1, 10'd4, 0, 4'b0, 8'h0, 0), 0);
        access(1, 1, 32'h0000_0010, 32'hA5A5_1234, mk(32'h0, 0, 2, 1, 10'd4, 0, 4'b0, 8'h0, 0), 0);
        // RAM read back: +2 cycles at latency 1, +4 at latency 3
        access(0, 0, 32'h0000_0010, 32'h0, mk(32'hA5A5_1234, 0, 2, 0, 10'd0, 0, 4'b0, 8'h0, 0), 0);
        access(1, 0, 32'h0000_0010, 32'h0, mk(32'hA5A5_1234, 0, 4, 0, 10'd0, 0, 4'b0, 8'h0, 0), 0);
        // write leaves cpu_rdata alone; second word reads back
        access(0, 1, 32'h0000_0020, 32'h0BAD_F00D, mk(32'hA5A5_1234, 0, 2, 1, 10'd8, 0, 4'b0, 8'h0, 0), 0);
        access(0, 0, 32'h0000_0020, 32'h0, mk(32'h0BAD_F00D, 0, 2, 0, 10'd0, 0, 4'b0, 8'h0, 0), 0);

        // IO read ch2 offset 1, ack in the 3rd selected cycle
        ack_at = 3; ack_bits = 4'b0100; stray_bits = 4'b0;
        access(1, 0, 32'hE000_0804, 32'h0, mk(32'h0000_0055, 0, 4, 0, 10'd0, 3, 4'b0100, 8'h01, 0), 0);
        // IO write ch1, never acked: timeout after 16 cycles; req dropped early
        ack_at = 0; ack_bits = 4'b0;
        access(1, 1, 32'hE000_0400, 32'h0000_0077, mk(32'hFFFF_FFFF, 1, 17, 0, 10'd0, 16, 4'b0010, 8'h00, 1), 1);
        // RAM write after the timeout keeps the all-ones read data
        access(1, 1, 32'h0000_0030, 32'h1234_5678, mk(32'hFFFF_FFFF, 0, 2, 1, 10'd12, 0, 4'b0, 8'h0, 0), 0);
        // ch3 selected, stray acks on ch0, real ack exactly at count 16
        ack_at = 16; ack_bits = 4'b1000; stray_bits = 4'b0001;
        access(1, 0, 32'hE000_0C08, 32'h0, mk(32'h3333_3333, 0, 17, 0, 10'd0, 16, 4'b1000, 8'h02, 0), 0);
        ack_at = 0; ack_bits = 4'b0; stray_bits = 4'b0;
        // nibble 0xD is not IO: goes to RAM word 12
        access(1, 0, 32'hD000_0030, 32'h0, mk(32'h1234_5678, 0, 4, 0, 10'd0, 0, 4'b0, 8'h0, 0), 0);

        // reset in the middle of a latency-3 RAM read: abandoned, no mio_ready
        @(negedge clk);
        cpu_we = 1'b0; cpu_addr = 32'h0000_0010; req_b = 1'b1;
        @(negedge clk);
        rst = 1'b1; req_b = 1'b0;
        @(negedge clk);
        zchk("midrst_b", rd_b, rdin_b, iwd_b, ra_b, ia_b, sel_b, rdy_b, err_b, rwe_b, iwe_b);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        access(1, 0, 32'h0000_0010, 32'h0, mk(32'hA5A5_1234, 0, 4, 0, 10'd0, 0, 4'b0, 8'h0, 0), 0);

        repeat (3) @(negedge clk);
        check("queue_a_drained", q_a.size(), 32'd0);
        check("queue_b_drained", q_b.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
